// File: rtl/game_pkg.sv
// Shared definitions for the falling-block game: board geometry, the line-clear
// sequencer state encoding and the line-count to score mapping.
package game_pkg;

    localparam int unsigned ROWS = 20;
    localparam int unsigned COLS = 10;
    localparam int unsigned SCORE_W = 12;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StRead = 3'd1,
        StEval = 3'd2,
        StFill = 3'd3,
        StDone = 3'd4
    } state_e;

    // Anything beyond a four-line clear earns the four-line award.
    function automatic logic [SCORE_W-1:0] score_for(input int unsigned n);
        logic [SCORE_W-1:0] s;
        case (n)
            0:       s = 12'd0;
            1:       s = 12'd100;
            2:       s = 12'd300;
            3:       s = 12'd500;
            default: s = 12'd800;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/row_clear_seq.sv
// Line-clear sequencer: compacts the board RAM bottom-to-top in one pass, dropping
// full rows, copying kept rows down and zero-filling the vacated top rows.
module row_clear_seq #(
    parameter int unsigned ROWS = game_pkg::ROWS,
    parameter int unsigned COLS = game_pkg::COLS,
    parameter int unsigned AW   = 5
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(ROWS+1)-1:0]    lines,
    output logic [11:0]                  score_add,
    output logic                         mem_req,
    input  logic                         mem_gnt,
    output logic [AW-1:0]                mem_addr,
    output logic                         mem_rd,
    output logic                         mem_we,
    output logic [COLS-1:0]              mem_wdata,
    input  logic [COLS-1:0]              mem_rdata
);

    import game_pkg::state_e;
    import game_pkg::StIdle;
    import game_pkg::StRead;
    import game_pkg::StEval;
    import game_pkg::StFill;
    import game_pkg::StDone;
    import game_pkg::score_for;

    localparam int unsigned LW = $clog2(ROWS + 1);
    localparam logic [AW-1:0] LastRow = AW'(ROWS - 1);

    state_e          state_q;
    logic [AW-1:0]   src_q;
    logic [AW-1:0]   dst_q;
    logic [AW-1:0]   cnt_q;
    logic [COLS-1:0] row_q;
    logic            rvld_q;
    logic            busy_q;
    logic            done_q;
    logic [LW-1:0]   lines_q;
    logic [11:0]     score_q;

    logic [COLS-1:0] row_w;
    logic            row_full;
    logic            copy_w;
    logic            eval_adv;

    // RAM data is only valid in the first EVAL cycle; a stalled write replays row_q.
    assign row_w    = rvld_q ? mem_rdata : row_q;
    assign row_full = &row_w;
    assign copy_w   = (state_q == StEval) && !row_full && (dst_q != src_q);
    assign eval_adv = !copy_w || mem_gnt;

    always_comb begin
        mem_req   = 1'b0;
        mem_rd    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = dst_q;
        mem_wdata = '0;
        unique case (state_q)
            StRead: begin
                mem_req  = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = src_q;
            end
            StEval: begin
                if (copy_w) begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_wdata = row_w;
                end
            end
            StFill: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            row_q   <= '0;
            rvld_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lines_q <= '0;
            score_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    busy_q <= start;
                    if (start) begin
                        src_q   <= LastRow;
                        dst_q   <= LastRow;
                        cnt_q   <= '0;
                        state_q <= StRead;
                    end
                end
                StRead: begin
                    if (mem_gnt) begin
                        rvld_q  <= 1'b1;
                        state_q <= StEval;
                    end
                end
                StEval: begin
                    if (rvld_q) begin
                        row_q  <= mem_rdata;
                        rvld_q <= 1'b0;
                    end
                    if (eval_adv) begin
                        // With no full rows dst wraps below row 0 here, but is never used.
                        if (row_full) begin
                            cnt_q <= cnt_q + AW'(1);
                        end else begin
                            dst_q <= dst_q - AW'(1);
                        end
                        if (src_q != '0) begin
                            src_q   <= src_q - AW'(1);
                            state_q <= StRead;
                        end else if (row_full || (cnt_q != '0)) begin
                            state_q <= StFill;
                        end else begin
                            state_q <= StDone;
                        end
                    end
                end
                StFill: begin
                    if (mem_gnt) begin
                        if (dst_q == '0) begin
                            state_q <= StDone;
                        end else begin
                            dst_q <= dst_q - AW'(1);
                        end
                    end
                end
                StDone: begin
                    done_q  <= 1'b1;
                    lines_q <= LW'(cnt_q);
                    score_q <= score_for(32'(cnt_q));
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign lines     = lines_q;
    assign score_add = score_q;

endmodule

// File: tb/tb_row_clear_seq.sv
// Directed bench for row_clear_seq: a small board RAM model, constant and random
// grant, latency, compaction results, stall stability, start-while-busy and clr.
module tb_row_clear_seq;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic        busy;
    logic        done;
    logic [4:0]  lines;
    logic [11:0] score_add;
    logic        mem_req;
    logic        mem_gnt;
    logic [4:0]  mem_addr;
    logic        mem_rd;
    logic        mem_we;
    logic [9:0]  mem_wdata;
    logic [9:0]  mem_rdata;

    always #5 clk = ~clk;

    row_clear_seq #(
        .ROWS (20),
        .COLS (10),
        .AW   (5)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .lines     (lines),
        .score_add (score_add),
        .mem_req   (mem_req),
        .mem_gnt   (mem_gnt),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    logic [9:0] ram      [0:31];
    logic [9:0] init_img [0:19];
    logic [9:0] exp_img  [0:19];
    logic [9:0] snap_img [0:19];
    logic       load = 1'b0;
    logic       rnd_gnt = 1'b0;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int we_cnt = 0;
    int stall_cnt = 0;
    int stall_viol = 0;
    int rdwe_viol = 0;

    // Read data is garbage except the cycle after a granted read.
    always @(posedge clk) begin
        if (load) begin
            for (int r = 0; r < 20; r++) ram[r] <= init_img[r];
        end else if (mem_req && mem_gnt && mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        if (mem_req && mem_gnt && mem_rd) mem_rdata <= ram[mem_addr];
        else mem_rdata <= 10'($urandom);
    end

    logic       stall_p = 1'b0;
    logic [4:0] p_addr;
    logic       p_rd;
    logic       p_we;
    logic [9:0] p_wdata;

    always @(negedge clk) begin
        if (mem_rd && mem_we) rdwe_viol++;
        if (stall_p) begin
            if (mem_req !== 1'b1 || mem_addr !== p_addr || mem_rd !== p_rd ||
                mem_we !== p_we || mem_wdata !== p_wdata) stall_viol++;
        end
        stall_p = mem_req && !mem_gnt;
        p_addr  = mem_addr;
        p_rd    = mem_rd;
        p_we    = mem_we;
        p_wdata = mem_wdata;
        if (stall_p) stall_cnt++;
        if (done === 1'b1) done_cnt++;
        if (mem_req && mem_gnt && mem_we) we_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_gnt) mem_gnt = 1'($urandom_range(0, 1));
    endtask

    task automatic load_board();
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Golden compaction: keep non-full rows in order at the bottom, zero the rest.
    task automatic model(output int k);
        int d;
        d = 19;
        k = 0;
        for (int s = 19; s >= 0; s--) begin
            if (init_img[s] === 10'h3FF) begin
                k++;
            end else begin
                exp_img[d] = init_img[s];
                d--;
            end
        end
        while (d >= 0) begin
            exp_img[d] = '0;
            d--;
        end
    endtask

    task automatic run(output int lat);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 400; c++) begin
            tick();
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic check_ram(input string tag);
        for (int r = 0; r < 20; r++) chk($sformatf("%s row%0d", tag, r), 32'(ram[r]), 32'(exp_img[r]));
    endtask

    task automatic clear_img();
        for (int r = 0; r < 20; r++) init_img[r] = '0;
    endtask

    task automatic img_one_full();
        clear_img();
        init_img[19] = 10'h3FF;
        init_img[18] = 10'h001;
        for (int r = 0; r < 18; r++) init_img[r] = 10'(10'h100 + r);
    endtask

    int k;
    int lat;
    int w0;
    int d0;

    initial begin
        clr     = 1'b1;
        start   = 1'b0;
        mem_gnt = 1'b1;
        clear_img();
        tick();
        tick();
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset lines", 32'(lines), 0);
        chk("reset score", 32'(score_add), 0);
        chk("reset mem_req", 32'(mem_req), 0);
        chk("reset mem_rd", 32'(mem_rd), 0);
        chk("reset mem_we", 32'(mem_we), 0);
        clr = 1'b0;
        tick();

        // Empty board
        clear_img();
        load_board();
        model(k);
        w0 = we_cnt;
        d0 = done_cnt;
        run(lat);
        chk("empty latency", lat, 41);
        chk("empty busy at done", 32'(busy), 1);
        chk("empty lines", 32'(lines), 0);
        chk("empty score", 32'(score_add), 0);
        tick();
        chk("empty done pulse", 32'(done), 0);
        chk("empty busy after", 32'(busy), 0);
        chk("empty writes", we_cnt - w0, 0);
        chk("empty done count", done_cnt - d0, 1);
        check_ram("empty");

        // Row 19 full
        img_one_full();
        load_board();
        model(k);
        w0 = we_cnt;
        run(lat);
        chk("one latency", lat, 42);
        chk("one lines", 32'(lines), 1);
        chk("one score", 32'(score_add), 100);
        tick();
        chk("one writes", we_cnt - w0, 20);
        chk("one ram19", 32'(ram[19]), 32'h001);
        chk("one ram18", 32'(ram[18]), 32'h111);
        chk("one ram0", 32'(ram[0]), 0);
        check_ram("one");
        repeat (5) tick();
        chk("one lines held", 32'(lines), 1);
        chk("one score held", 32'(score_add), 100);

        // Rows 19 and 17 full
        clear_img();
        init_img[19] = 10'h3FF;
        init_img[18] = 10'h0AA;
        init_img[17] = 10'h3FF;
        init_img[16] = 10'h055;
        for (int r = 0; r < 16; r++) init_img[r] = 10'(10'h200 | r);
        load_board();
        model(k);
        w0 = we_cnt;
        run(lat);
        chk("two latency", lat, 43);
        chk("two lines", 32'(lines), 2);
        chk("two score", 32'(score_add), 300);
        tick();
        chk("two writes", we_cnt - w0, 20);
        chk("two ram19", 32'(ram[19]), 32'h0AA);
        chk("two ram18", 32'(ram[18]), 32'h055);
        chk("two ram1", 32'(ram[1]), 0);
        chk("two ram0", 32'(ram[0]), 0);
        check_ram("two");

        // Four full rows: constant grant, then random grant on the same image
        for (int r = 0; r < 20; r++) init_img[r] = 10'(10'h040 + r);
        init_img[19] = 10'h3FF;
        init_img[15] = 10'h3FF;
        init_img[10] = 10'h3FF;
        init_img[3]  = 10'h3FF;
        load_board();
        model(k);
        run(lat);
        chk("four latency", lat, 45);
        chk("four lines", 32'(lines), 4);
        chk("four score", 32'(score_add), 800);
        tick();
        check_ram("four");
        for (int r = 0; r < 20; r++) snap_img[r] = ram[r];
        load_board();
        stall_cnt  = 0;
        stall_viol = 0;
        rdwe_viol  = 0;
        rnd_gnt    = 1'b1;
        run(lat);
        rnd_gnt = 1'b0;
        mem_gnt = 1'b1;
        chk("rand latency", lat, 45 + stall_cnt);
        chk("rand lines", 32'(lines), 4);
        chk("rand score", 32'(score_add), 800);
        tick();
        for (int r = 0; r < 20; r++) chk($sformatf("rand row%0d", r), 32'(ram[r]), 32'(snap_img[r]));
        chk("rand stalls seen", 32'(stall_cnt > 0), 1);
        chk("rand stall stability", stall_viol, 0);
        chk("rand rd/we exclusive", rdwe_viol, 0);

        // Five full rows at the top saturate the score
        clear_img();
        for (int r = 0; r < 5; r++) init_img[r] = 10'h3FF;
        load_board();
        model(k);
        w0 = we_cnt;
        run(lat);
        chk("five latency", lat, 46);
        chk("five lines", 32'(lines), 5);
        chk("five score", 32'(score_add), 800);
        tick();
        chk("five writes", we_cnt - w0, 5);
        check_ram("five");

        // start while busy is ignored
        img_one_full();
        load_board();
        model(k);
        d0 = done_cnt;
        start = 1'b1;
        tick();
        lat = -1;
        for (int c = 1; c <= 400; c++) begin
            start = (c == 5);
            tick();
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
        start = 1'b0;
        chk("busy-start latency", lat, 42);
        repeat (50) tick();
        chk("busy-start done count", done_cnt - d0, 1);
        chk("busy-start idle", 32'(busy), 0);
        chk("busy-start lines", 32'(lines), 1);

        // clr mid-run
        clear_img();
        load_board();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        chk("pre-clr busy", 32'(busy), 1);
        clr = 1'b1;
        tick();
        chk("clr busy", 32'(busy), 0);
        chk("clr done", 32'(done), 0);
        chk("clr mem_req", 32'(mem_req), 0);
        chk("clr mem_rd", 32'(mem_rd), 0);
        chk("clr mem_we", 32'(mem_we), 0);
        chk("clr lines", 32'(lines), 0);
        chk("clr score", 32'(score_add), 0);
        clr = 1'b0;
        tick();
        img_one_full();
        load_board();
        model(k);
        run(lat);
        chk("post-clr latency", lat, 42);
        chk("post-clr lines", 32'(lines), 1);
        chk("post-clr score", 32'(score_add), 100);
        tick();
        check_ram("post-clr");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
